// File: rtl/serial_add_sub_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller:
// state encoding, default operand width and the slice-count derivation.
package serial_add_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int DEFAULT_WIDTH = 32;

  function automatic int nibbles_of(input int width);
    return width / 4;
  endfunction

endpackage

// File: rtl/serial_add_sub_ctrl_cla.sv
// 4-bit carry-lookahead slice: nibble sum plus block propagate/generate,
// which the controller turns into the registered inter-nibble carry.
module cla_4_bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_in_i,
  output logic [3:0] sum_o,
  output logic       p_o,
  output logic       g_o
);

  logic [3:0] p_w;
  logic [3:0] g_w;
  logic [3:0] c_w;

  assign p_w = a_i ^ b_i;
  assign g_w = a_i & b_i;

  assign c_w[0] = c_in_i;
  assign c_w[1] = g_w[0] | (p_w[0] & c_in_i);
  assign c_w[2] = g_w[1] | (p_w[1] & g_w[0]) | (p_w[1] & p_w[0] & c_in_i);
  assign c_w[3] = g_w[2] | (p_w[2] & g_w[1]) | (p_w[2] & p_w[1] & g_w[0])
                | (p_w[2] & p_w[1] & p_w[0] & c_in_i);

  assign sum_o = p_w ^ c_w;
  assign p_o   = &p_w;
  assign g_o   = g_w[3] | (p_w[3] & g_w[2]) | (p_w[3] & p_w[2] & g_w[1])
               | (p_w[3] & p_w[2] & p_w[1] & g_w[0]);

endmodule

// File: rtl/serial_add_sub_ctrl.sv
// Multi-cycle add/subtract that time-shares one 4-bit CLA slice, LSB nibble first.
// state | meaning: IDLE | waiting for start; RUN | one nibble per cycle; DONE | result valid, done high
module serial_add_sub_ctrl
  import serial_add_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_out_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int NIBBLES = nibbles_of(WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_q, b_q, result_q, result_d;
  logic               carry_q, carry_d;
  logic               carry_out_q, overflow_q, zero_q;
  logic               accept_w, last_w;
  logic [3:0]         a_nib_w, b_nib_w, sum_w;
  logic               p_w, g_w;

  // start is only honoured outside RUN so an in-flight operation is never disturbed
  assign accept_w = start_i && (state_q != ST_RUN);
  assign last_w   = (idx_q == LAST_IDX);

  assign a_nib_w = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib_w = b_q[{idx_q, 2'b00} +: 4];

  cla_4_bit u_slice (
    .a_i    (a_nib_w),
    .b_i    (b_nib_w),
    .c_in_i (carry_q),
    .sum_o  (sum_w),
    .p_o    (p_w),
    .g_o    (g_w)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = g_w | (p_w & carry_q);
    result_d[{idx_q, 2'b00} +: 4] = sum_w;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN:  if (last_w)  state_d = ST_DONE;
      ST_DONE: state_d = start_i ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_w) begin
        a_q      <= a_i;
        b_q      <= op_sub_i ? ~b_i : b_i;
        carry_q  <= op_sub_i;
        idx_q    <= '0;
        result_q <= '0;
      end else if (state_q == ST_RUN) begin
        result_q <= result_d;
        carry_q  <= carry_d;
        idx_q    <= last_w ? '0 : idx_q + 1'b1;
        if (last_w) begin
          carry_out_q <= carry_d;
          overflow_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[3] != a_q[WIDTH-1]);
          zero_q      <= (result_d == '0);
        end
      end
    end
  end

  assign busy_o      = (state_q == ST_RUN);
  assign done_o      = (state_q == ST_DONE);
  assign result_o    = result_q;
  assign carry_out_o = carry_out_q;
  assign overflow_o  = overflow_q;
  assign zero_o      = zero_q;

endmodule
